// File: rtl/riscv_bus_pkg.sv
// Shared bus types and RAM memory-map defaults for the SoC fabric.
package riscv_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    localparam logic [ADDR_W-1:0] RAM_BASE_DEFAULT = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] RAM_SIZE_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } bus_req_t;

    // Unsigned offset compare: addresses below base wrap to a huge offset and fall out.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W-1:0] size);
        logic [ADDR_W-1:0] offs;
        offs = addr - base;
        return offs < size;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on contention the master that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid_c,
    output logic       pick_c
);

    always_comb begin
        valid_c = |req;
        pick_c  = 1'b0;
        if (req[0] && req[1]) begin
            pick_c = ~last;
        end else if (req[1]) begin
            pick_c = 1'b1;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter/sequencer for the single RAM slave port; one transaction in flight.
// Optional bus watchdog enabled by defining BUS_TIMEOUT_EN.
module ram_port_arbiter
    import riscv_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RAM_BASE       = RAM_BASE_DEFAULT,
    parameter logic [ADDR_W-1:0] RAM_SIZE       = RAM_SIZE_DEFAULT,
    parameter int unsigned       TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    output logic              m0_error,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              m1_error,
    output logic              s_req,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ready,
    output logic              grant_id
);

    arb_state_e        state;
    bus_req_t          pay;
    bus_req_t          win_pl;
    logic              last;
    logic              gnt_valid_c;
    logic              gnt_pick_c;
    logic              resp_valid_c;
    logic              resp_err_c;
    logic [DATA_W-1:0] resp_rdata_c;
    logic              timeout_c;

    rr_arb2 u_rr_arb2 (
        .req     ({m1_req, m0_req}),
        .last    (last),
        .valid_c (gnt_valid_c),
        .pick_c  (gnt_pick_c)
    );

    assign win_pl = gnt_pick_c ? bus_req_t'{m1_we, m1_addr, m1_wdata, m1_wstrb}
                               : bus_req_t'{m0_we, m0_addr, m0_wdata, m0_wstrb};

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (state == BUSY && !s_ready) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign timeout_c = (state == BUSY) && !s_ready && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // Sequencer: grant, payload latch, slave request and return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s_req    <= 1'b0;
            pay      <= '0;
            grant_id <= 1'b0;
            last     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid_c) begin
                        pay      <= win_pl;
                        grant_id <= gnt_pick_c;
                        last     <= gnt_pick_c;
                        if (in_window(win_pl.addr, RAM_BASE, RAM_SIZE)) begin
                            state <= BUSY;
                            s_req <= 1'b1;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                BUSY: begin
                    if (s_ready || timeout_c) begin
                        s_req <= 1'b0;
                        state <= IDLE;
                    end
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    s_req <= 1'b0;
                end
            endcase
        end
    end

    assign s_we    = pay.we;
    assign s_addr  = pay.addr;
    assign s_wdata = pay.wdata;
    assign s_wstrb = pay.wstrb;

    // Response is combinational off the completing cycle; stray s_ready outside BUSY is dropped.
    always_comb begin
        resp_valid_c = 1'b0;
        resp_err_c   = 1'b0;
        resp_rdata_c = '0;
        case (state)
            BUSY: begin
                if (s_ready) begin
                    resp_valid_c = 1'b1;
                    resp_rdata_c = pay.we ? '0 : s_rdata;
                end else if (timeout_c) begin
                    resp_valid_c = 1'b1;
                    resp_err_c   = 1'b1;
                end
            end
            ERR: begin
                resp_valid_c = 1'b1;
                resp_err_c   = 1'b1;
            end
            default: ;
        endcase
    end

    assign m0_ready = resp_valid_c && !grant_id;
    assign m0_error = resp_err_c && !grant_id;
    assign m0_rdata = (resp_valid_c && !grant_id) ? resp_rdata_c : '0;
    assign m1_ready = resp_valid_c && grant_id;
    assign m1_error = resp_err_c && grant_id;
    assign m1_rdata = (resp_valid_c && grant_id) ? resp_rdata_c : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: per-master expected queues, negedge monitor, RAM model.
// Timeout scenario compiled in when BUS_TIMEOUT_EN is defined.
module tb_ram_port_arbiter;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk;
    logic        rst_n;
    logic        req[2];
    logic        we[2];
    logic [31:0] addr[2];
    logic [31:0] wdata[2];
    logic [3:0]  wstrb[2];
    logic [31:0] rdata[2];
    logic        ready[2];
    logic        error[2];
    logic        s_req, s_we, s_ready, grant_id;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        model_ready, stray_ready, ram_en;

    int   vectors = 0;
    int   miscompares = 0;
    rsp_t exp0[$];
    rsp_t exp1[$];
    int   grant_log[$];
    logic [31:0] mem [logic [31:0]];

    assign s_ready = model_ready | stray_ready;

    ram_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]),
        .m0_rdata(rdata[0]), .m0_ready(ready[0]), .m0_error(error[0]),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]),
        .m1_rdata(rdata[1]), .m1_ready(ready[1]), .m1_error(error[1]),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM model: answers 2 cycles into a request; unwritten words read as addr ^ KEY.
    int lat_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (ram_en) begin
            if (s_req && !model_ready) begin
                if (lat_cnt == 1) begin
                    model_ready = 1'b1;
                    lat_cnt = 0;
                    if (s_we) begin
                        logic [31:0] old;
                        old = mem.exists(s_addr) ? mem[s_addr] : (s_addr ^ KEY);
                        for (int b = 0; b < 4; b++)
                            if (s_wstrb[b]) old[b*8 +: 8] = s_wdata[b*8 +: 8];
                        mem[s_addr] = old;
                        s_rdata = 32'h0BAD_F00D;
                    end else begin
                        s_rdata = mem.exists(s_addr) ? mem[s_addr] : (s_addr ^ KEY);
                    end
                end else begin
                    lat_cnt++;
                end
            end else begin
                model_ready = 1'b0;
                lat_cnt = 0;
            end
        end
    end

    // Monitor: pops the responding master's expected response; idle master must stay quiet.
    always @(negedge clk) begin
        if (ready[0] && ready[1]) begin
            chk("dual_ready", 32'({ready[0], ready[1]}), 32'h0);
        end
        for (int m = 0; m < 2; m++) begin
            if (ready[m]) begin
                rsp_t e;
                int   depth;
                depth = (m == 0) ? exp0.size() : exp1.size();
                if (depth == 0) begin
                    chk($sformatf("unexpected_ready_m%0d", m), 32'(ready[m]), 32'h0);
                end else begin
                    e = (m == 0) ? exp0.pop_front() : exp1.pop_front();
                    chk($sformatf("err_m%0d", m), 32'(error[m]), 32'(e.err));
                    chk($sformatf("rdata_m%0d", m), rdata[m], e.rdata);
                    chk($sformatf("grant_id_m%0d", m), 32'(grant_id), 32'(m));
                    grant_log.push_back(m);
                end
            end else begin
                chk($sformatf("quiet_m%0d", m), {error[m], rdata[m][30:0]} | 32'(rdata[m][31]), 32'h0);
            end
        end
    end

    task automatic do_txn(input int m, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic e_err, input logic [31:0] e_rdata);
        rsp_t r;
        int   n;
        r.err   = e_err;
        r.rdata = e_rdata;
        if (m == 0) exp0.push_back(r); else exp1.push_back(r);
        we[m] = w; addr[m] = a; wdata[m] = d; wstrb[m] = s; req[m] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready[m] && n < 60);
        if (!ready[m]) begin
            chk($sformatf("txn_done_m%0d", m), 32'(ready[m]), 32'h1);
            if (m == 0) void'(exp0.pop_back()); else void'(exp1.pop_back());
        end
        @(posedge clk);
        #1;
        req[m] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: got running want finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int exp_gl[6] = '{0, 1, 0, 1, 0, 1};
        for (int m = 0; m < 2; m++) begin
            req[m] = 0; we[m] = 0; addr[m] = 0; wdata[m] = 0; wstrb[m] = 0;
        end
        rst_n = 1'b0; ram_en = 1'b1; model_ready = 1'b0; stray_ready = 1'b0; s_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_s_req", 32'(s_req), 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_payload", {s_wdata[27:0], s_wstrb} | 32'(s_we), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single read: s_req one cycle after request, RAM data returned to m0.
        chk("pre_s_req", 32'(s_req), 32'h0);
        fork
            do_txn(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 32'hDEAD_0100);
            begin
                @(posedge clk); #1;
                chk("s_req_latency", 32'(s_req), 32'h1);
                chk("s_addr_latched", s_addr, 32'h100);
            end
        join

        // Out-of-window write by m1: error pulse next cycle, no slave request.
        fork
            do_txn(1, 1'b1, 32'h0040_0000, 32'hCAFE, 4'hF, 1'b1, 32'h0);
            begin
                @(negedge clk);
                chk("err_not_early", 32'(ready[1]), 32'h0);
                @(negedge clk);
                chk("err_pulse", 32'({ready[1], error[1]}), 32'h3);
                chk("err_no_s_req", 32'(s_req), 32'h0);
                @(negedge clk);
                chk("err_no_s_req_after", 32'(s_req), 32'h0);
            end
        join

        // Stray s_ready while IDLE must not produce any response.
        ram_en = 1'b0;
        stray_ready = 1'b1; s_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("stray_ignored", 32'({ready[0], ready[1]}), 32'h0);
        stray_ready = 1'b0;
        ram_en = 1'b1;
        @(posedge clk); #1;

        // Both masters requesting continuously: strict alternation, m0 first.
        grant_log.delete();
        fork
            begin
                do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEAD_0010);
                do_txn(0, 1'b0, 32'h2000, 32'h0, 4'h0, 1'b0, 32'hDEAD_2000);
                do_txn(0, 1'b0, 32'h44, 32'h0, 4'h0, 1'b0, 32'hDEAD_5678);
            end
            begin
                do_txn(1, 1'b1, 32'h44, 32'h1234_5678, 4'b0011, 1'b0, 32'h0);
                do_txn(1, 1'b1, 32'h003F_FFFC, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0);
                do_txn(1, 1'b0, 32'h003F_FFFC, 32'h0, 4'h0, 1'b0, 32'hA5A5_A5A5);
            end
        join
        chk("alt_count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk($sformatf("alt_grant_%0d", i), 32'(grant_log[i]), 32'(exp_gl[i]));

`ifdef BUS_TIMEOUT_EN
        // Silent RAM: watchdog error after 8 BUSY cycles, late s_ready dropped.
        ram_en = 1'b0;
        fork
            do_txn(0, 1'b0, 32'h500, 32'h0, 4'h0, 1'b1, 32'h0);
            begin
                int first = -1;
                int hit = -1;
                for (int k = 1; k <= 30 && hit < 0; k++) begin
                    @(negedge clk);
                    if (s_req && first < 0) first = k;
                    if (error[0]) hit = k;
                end
                chk("timeout_busy_cycles", 32'(hit - first + 1), 32'd8);
            end
        join
        stray_ready = 1'b1; s_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("late_ready_ignored", 32'({ready[0], ready[1]}), 32'h0);
        stray_ready = 1'b0;
        ram_en = 1'b1;
        @(posedge clk); #1;
`endif

        // Reset in the middle of a BUSY transaction (m0 granted, so last=0 before reset).
        ram_en = 1'b0;
        we[0] = 1'b0; addr[0] = 32'h200; req[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("busy_s_req", 32'(s_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_s_req", 32'(s_req), 32'h0);
        chk("async_rst_s_addr", s_addr, 32'h0);
        chk("async_rst_grant", 32'(grant_id), 32'h0);
        req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ram_en = 1'b1;
        @(posedge clk); #1;
        grant_log.delete();
        fork
            do_txn(0, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0, 32'hDEAD_0300);
            do_txn(1, 1'b0, 32'h304, 32'h0, 4'h0, 1'b0, 32'hDEAD_0304);
        join
        chk("post_rst_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() > 0)
            chk("post_rst_first_grant", 32'(grant_log[0]), 32'h0);
        chk("leftover_exp", 32'(exp0.size() + exp1.size()), 32'h0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
